// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, functs,
// ALU operation codes, FSM states and decoded instruction classes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_RTYPE, CL_ITYPE, CL_LOAD, CL_STORE, CL_JUMP, CL_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: classifies the IR word and picks the ALU
// operation and EXT16 sign mode it needs.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     iclass,
  output logic [2:0]  aluc,
  output logic        ext_sign
);

  always_comb begin
    iclass   = CL_ILLEGAL;
    aluc     = ALU_ADD;
    ext_sign = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        if (ir == '0) begin
          iclass = CL_NOP;
        end else begin
          iclass = CL_RTYPE;
          case (ir[5:0])
            FN_ADD:  aluc = ALU_ADD;
            FN_SUB:  aluc = ALU_SUB;
            FN_AND:  aluc = ALU_AND;
            FN_OR:   aluc = ALU_OR;
            FN_SLT:  aluc = ALU_SLT;
            default: iclass = CL_ILLEGAL;
          endcase
        end
      end
      OP_ADDI: begin iclass = CL_ITYPE; aluc = ALU_ADD; ext_sign = 1'b1; end
      OP_SLTI: begin iclass = CL_ITYPE; aluc = ALU_SLT; ext_sign = 1'b1; end
      OP_ANDI: begin iclass = CL_ITYPE; aluc = ALU_AND; end
      OP_ORI:  begin iclass = CL_ITYPE; aluc = ALU_OR;  end
      OP_LW:   begin iclass = CL_LOAD;  ext_sign = 1'b1; end
      OP_SW:   begin iclass = CL_STORE; ext_sign = 1'b1; end
      OP_J:    iclass = CL_JUMP;
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back over
// one shared request/ready memory port, counts retired instructions, traps on illegal words.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_src,
  output logic             ir_w,
  output logic             pc_w,
  output logic             pc_src,
  output logic             ab_w,
  output logic             alu_b_src,
  output logic             ext_sign,
  output logic [2:0]       aluc,
  output logic             aluout_w,
  output logic             rf_w,
  output logic             rf_dst,
  output logic             wb_src,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_t     state, state_nx;
  iclass_t    iclass;
  logic [2:0] dec_aluc;
  logic       dec_ext;
  logic       retire;
  logic       trap_set;

  mc_decode u_decode (
    .ir       (ir),
    .iclass   (iclass),
    .aluc     (dec_aluc),
    .ext_sign (dec_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap    <= 1'b0;
      instret <= '0;
    end else begin
      if (trap_set) trap    <= 1'b1;
      if (retire)   instret <= instret + CNT_W'(1);
    end
  end

  // Decode is gated by rst so a reset mid-request drops mem_req in the same cycle.
  always_comb begin
    state_nx  = state;
    retire    = 1'b0;
    trap_set  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_src  = 1'b0;
    ir_w      = 1'b0;
    pc_w      = 1'b0;
    pc_src    = 1'b0;
    ab_w      = 1'b0;
    alu_b_src = 1'b0;
    ext_sign  = 1'b0;
    aluc      = ALU_ADD;
    aluout_w  = 1'b0;
    rf_w      = 1'b0;
    rf_dst    = 1'b0;
    wb_src    = 1'b0;
    if (rst) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_w     = 1'b1;
            pc_w     = 1'b1;
            state_nx = DECODE;
          end
        end
        DECODE: begin
          ab_w = 1'b1;
          case (iclass)
            CL_NOP:   begin retire = 1'b1; state_nx = FETCH; end
            CL_JUMP:  begin pc_w = 1'b1; pc_src = 1'b1; retire = 1'b1; state_nx = FETCH; end
            CL_RTYPE: state_nx = EXEC_R;
            CL_ITYPE: state_nx = EXEC_I;
            CL_LOAD,
            CL_STORE: state_nx = MEM_ADDR;
            default:  begin trap_set = 1'b1; state_nx = TRAP; end
          endcase
        end
        EXEC_R: begin
          alu_b_src = 1'b1;
          aluc      = dec_aluc;
          aluout_w  = 1'b1;
          state_nx  = WB_ALU;
        end
        EXEC_I: begin
          aluc     = dec_aluc;
          ext_sign = dec_ext;
          aluout_w = 1'b1;
          state_nx = WB_ALU;
        end
        WB_ALU: begin
          rf_w     = 1'b1;
          rf_dst   = (iclass == CL_ITYPE);
          retire   = 1'b1;
          state_nx = FETCH;
        end
        MEM_ADDR: begin
          aluc     = ALU_ADD;
          ext_sign = dec_ext;
          aluout_w = 1'b1;
          state_nx = (iclass == CL_STORE) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          mem_req  = 1'b1;
          addr_src = 1'b1;
          if (mem_ready) state_nx = WB_MEM;
        end
        WB_MEM: begin
          rf_w     = 1'b1;
          rf_dst   = 1'b1;
          wb_src   = 1'b1;
          retire   = 1'b1;
          state_nx = FETCH;
        end
        MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_src = 1'b1;
          if (mem_ready) begin
            retire   = 1'b1;
            state_nx = FETCH;
          end
        end
        TRAP:    state_nx = TRAP;
        default: state_nx = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: expected per-cycle control vectors are built
// from each instruction's class and the chosen memory wait counts.
module tb_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_ready;
  logic [31:0] ir;

  logic mem_req, mem_we, addr_src, ir_w, pc_w, pc_src, ab_w, alu_b_src, ext_sign;
  logic aluout_w, rf_w, rf_dst, wb_src, trap;
  logic [2:0]  aluc;
  logic [31:0] instret;

  logic mem_req4, mem_we4, addr_src4, ir_w4, pc_w4, pc_src4, ab_w4, alu_b_src4, ext_sign4;
  logic aluout_w4, rf_w4, rf_dst4, wb_src4, trap4;
  logic [2:0] aluc4;
  logic [3:0] instret4;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_w(ir_w),
    .pc_w(pc_w), .pc_src(pc_src), .ab_w(ab_w), .alu_b_src(alu_b_src),
    .ext_sign(ext_sign), .aluc(aluc), .aluout_w(aluout_w), .rf_w(rf_w),
    .rf_dst(rf_dst), .wb_src(wb_src), .trap(trap), .instret(instret)
  );

  mc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready),
    .mem_req(mem_req4), .mem_we(mem_we4), .addr_src(addr_src4), .ir_w(ir_w4),
    .pc_w(pc_w4), .pc_src(pc_src4), .ab_w(ab_w4), .alu_b_src(alu_b_src4),
    .ext_sign(ext_sign4), .aluc(aluc4), .aluout_w(aluout_w4), .rf_w(rf_w4),
    .rf_dst(rf_dst4), .wb_src(wb_src4), .trap(trap4), .instret(instret4)
  );

  logic [15:0] obs, obs4;
  assign obs  = {mem_req, mem_we, addr_src, ir_w, pc_w, pc_src, ab_w, alu_b_src,
                 ext_sign, aluc, aluout_w, rf_w, rf_dst, wb_src};
  assign obs4 = {mem_req4, mem_we4, addr_src4, ir_w4, pc_w4, pc_src4, ab_w4, alu_b_src4,
                 ext_sign4, aluc4, aluout_w4, rf_w4, rf_dst4, wb_src4};

  localparam logic [15:0] E_REQ  = 16'h8000, E_WE   = 16'h4000, E_AS  = 16'h2000;
  localparam logic [15:0] E_IRW  = 16'h1000, E_PCW  = 16'h0800, E_PCS = 16'h0400;
  localparam logic [15:0] E_AB   = 16'h0200, E_BSRC = 16'h0100, E_EXT = 16'h0080;
  localparam logic [15:0] E_ALUC = 16'h0070, E_AOW  = 16'h0008, E_RFW = 16'h0004;
  localparam logic [15:0] E_DST  = 16'h0002, E_WB   = 16'h0001;

  typedef struct {
    logic        rdy;
    logic [15:0] e;
    logic        retire;
    logic        trap_next;
    logic        load_ir;
    logic [31:0] word;
  } cyc_t;

  cyc_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cnt = 0;
  logic        trap_exp = 1'b0;

  // Qualifier bits are only meaningful while the signal they qualify is active.
  function automatic logic [15:0] care_of(input logic [15:0] e);
    logic [15:0] m;
    m = E_REQ | E_IRW | E_PCW | E_AB | E_AOW | E_RFW;
    if ((e & E_REQ) != '0) m = m | E_WE | E_AS;
    if ((e & E_PCW) != '0) m = m | E_PCS;
    if ((e & E_AOW) != '0) m = m | E_BSRC | E_ALUC;
    if ((e & E_AOW) != '0 && (e & E_BSRC) == '0) m = m | E_EXT;
    if ((e & E_RFW) != '0) m = m | E_DST | E_WB;
    return m;
  endfunction

  function automatic logic [15:0] alu_f(input logic [31:0] w);
    logic [2:0] a;
    a = 3'd0;
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h22: a = 3'd1;
        6'h24: a = 3'd2;
        6'h25: a = 3'd3;
        6'h2A: a = 3'd4;
        default: a = 3'd0;
      endcase
    end else begin
      case (w[31:26])
        6'h0C: a = 3'd2;
        6'h0D: a = 3'd3;
        6'h0A: a = 3'd4;
        default: a = 3'd0;
      endcase
    end
    return {9'b0, a, 4'b0};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 12))
      0:  return {6'h00, rs, rt, rd, 5'h0, 6'h20};
      1:  return {6'h00, rs, rt, rd, 5'h0, 6'h22};
      2:  return {6'h00, rs, rt, rd, 5'h0, 6'h24};
      3:  return {6'h00, rs, rt, rd, 5'h0, 6'h25};
      4:  return {6'h00, rs, rt, rd, 5'h0, 6'h2A};
      5:  return 32'h0;
      6:  return {6'h08, rs, rt, imm};
      7:  return {6'h0C, rs, rt, imm};
      8:  return {6'h0D, rs, rt, imm};
      9:  return {6'h0A, rs, rt, imm};
      10: return {6'h23, rs, rt, imm};
      11: return {6'h2B, rs, rt, imm};
      default: return {6'h02, 26'($urandom)};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic push(input logic rdy, input logic [15:0] e, input logic ret,
                      input logic tn, input logic ld, input logic [31:0] w);
    cyc_t c;
    c.rdy       = ((e & E_REQ) != '0) ? rdy : 1'($urandom_range(0, 1));
    c.e         = e;
    c.retire    = ret;
    c.trap_next = tn;
    c.load_ir   = ld;
    c.word      = w;
    q.push_back(c);
  endtask

  task automatic gen_fetch(input logic [31:0] w, input int unsigned fw);
    repeat (fw) push(1'b0, E_REQ, 1'b0, 1'b0, 1'b0, '0);
    push(1'b1, E_REQ | E_IRW | E_PCW, 1'b0, 1'b0, 1'b1, w);
  endtask

  task automatic gen_instr(input logic [31:0] w, input int unsigned fw, input int unsigned mw);
    logic [5:0]  op;
    logic [15:0] sx;
    op = w[31:26];
    sx = (op == 6'h08 || op == 6'h0A) ? E_EXT : 16'h0;
    gen_fetch(w, fw);
    if (w == 32'h0) begin
      push(1'b0, E_AB, 1'b1, 1'b0, 1'b0, '0);
    end else if (op == 6'h02) begin
      push(1'b0, E_AB | E_PCW | E_PCS, 1'b1, 1'b0, 1'b0, '0);
    end else if (op == 6'h00) begin
      push(1'b0, E_AB, 1'b0, 1'b0, 1'b0, '0);
      push(1'b0, E_BSRC | E_AOW | alu_f(w), 1'b0, 1'b0, 1'b0, '0);
      push(1'b0, E_RFW, 1'b1, 1'b0, 1'b0, '0);
    end else if (op == 6'h23) begin
      push(1'b0, E_AB, 1'b0, 1'b0, 1'b0, '0);
      push(1'b0, E_AOW | E_EXT, 1'b0, 1'b0, 1'b0, '0);
      repeat (mw) push(1'b0, E_REQ | E_AS, 1'b0, 1'b0, 1'b0, '0);
      push(1'b1, E_REQ | E_AS, 1'b0, 1'b0, 1'b0, '0);
      push(1'b0, E_RFW | E_DST | E_WB, 1'b1, 1'b0, 1'b0, '0);
    end else if (op == 6'h2B) begin
      push(1'b0, E_AB, 1'b0, 1'b0, 1'b0, '0);
      push(1'b0, E_AOW | E_EXT, 1'b0, 1'b0, 1'b0, '0);
      repeat (mw) push(1'b0, E_REQ | E_WE | E_AS, 1'b0, 1'b0, 1'b0, '0);
      push(1'b1, E_REQ | E_WE | E_AS, 1'b1, 1'b0, 1'b0, '0);
    end else begin
      push(1'b0, E_AB, 1'b0, 1'b0, 1'b0, '0);
      push(1'b0, E_AOW | sx | alu_f(w), 1'b0, 1'b0, 1'b0, '0);
      push(1'b0, E_RFW | E_DST, 1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic gen_illegal(input logic [31:0] w, input int unsigned fw, input int unsigned hold);
    gen_fetch(w, fw);
    push(1'b0, E_AB, 1'b0, 1'b1, 1'b0, '0);
    repeat (hold) push(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic run();
    cyc_t        c;
    logic [15:0] m;
    while (q.size() > 0) begin
      c = q.pop_front();
      m = care_of(c.e);
      @(negedge clk);
      mem_ready = c.rdy;
      #1;
      chk("ctrl", 32'(obs & m), 32'(c.e & m));
      chk("ctrl4", 32'(obs4 & m), 32'(c.e & m));
      chk("instret", instret, 32'(cnt));
      chk("instret4", 32'(instret4), 32'(cnt & 32'hF));
      chk("trap", 32'(trap), 32'(trap_exp));
      @(posedge clk);
      #1;
      if (c.load_ir)   ir = c.word;
      if (c.retire)    cnt++;
      if (c.trap_next) trap_exp = 1'b1;
    end
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst_ctrl", 32'(obs), 32'h0);
    chk("rst_trap", 32'(trap), 32'h0);
    chk("rst_instret", instret, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ready = 1'b0;
    cnt = 0;
    trap_exp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    mem_ready = 1'b1;
    ir = 32'h0;
    do_reset();

    gen_instr(32'h00221820, 0, 0); run();
    gen_instr(32'h8C220004, 0, 3); run();
    gen_instr(32'hAC220008, 0, 0); gen_instr(32'h08000004, 0, 0); run();
    gen_instr(32'h30220F0F, 0, 0); gen_instr(32'h2822FFFF, 0, 0); run();
    gen_instr(32'h00000000, 2, 0); gen_instr(32'h00221822, 1, 0);
    gen_instr(32'hAC220008, 2, 2); run();

    for (int i = 0; i < 80; i++) begin
      gen_instr(rand_word(), $urandom_range(0, 3), $urandom_range(0, 3));
      run();
    end

    do_reset();
    repeat (15) gen_instr(32'h0, 0, 0);
    run();
    chk("wrap_ones", 32'(instret4), 32'hF);
    gen_instr(32'h0, 0, 0);
    run();
    chk("wrap_zero", 32'(instret4), 32'h0);
    chk("wrap_full", instret, 32'd16);

    do_reset();
    gen_instr(32'h00221820, 0, 0);
    gen_illegal(32'hFC000000, 1, 20);
    run();
    do_reset();
    gen_illegal(32'h00221821, 0, 3);
    run();
    do_reset();

    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("midwait_req", 32'(mem_req), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("midwait_drop", 32'(obs), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cnt = 0;
    trap_exp = 1'b0;
    gen_instr(32'h00221820, 0, 0);
    run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-subset datapath (PC, NPC, JOINT, RegFile, EXT16, ALU, shared memory port). It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select. It owns a single memory request/ready handshake, so instruction fetch and data access share one variable-latency port. It also keeps a retired-instruction counter and a sticky trap for unsupported encodings.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ir  in  32  instruction register contents (loaded via ir_w)
- mem_ready  in  1  memory completed the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  request is a write (valid with mem_req)
- addr_src  out  1  memory address: 0 = PC, 1 = ALU-out register
- ir_w  out  1  load IR from memory read data
- pc_w  out  1  load PC
- pc_src  out  1  PC input: 0 = NPC (PC+4), 1 = JOINT jump target
- ab_w  out  1  latch RegFile rs/rt into A/B registers
- alu_b_src  out  1  ALU B: 0 = EXT16 output, 1 = B register
- ext_sign  out  1  EXT16 sign-extend enable
- aluc  out  3  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 slt
- aluout_w  out  1  latch ALU result
- rf_w  out  1  RegFile write enable
- rf_dst  out  1  write address: 0 = ir[15:11], 1 = ir[20:16]
- wb_src  out  1  write data: 0 = ALU-out, 1 = memory data register
- trap  out  1  sticky: unsupported instruction seen
- instret  out  CNT_W  retired-instruction count

## Operation
- Supported: add, sub, and, or, slt (op 0, funct 20/22/24/25/2A hex), nop (word 0), addi 08, andi 0C, ori 0D, slti 0A, lw 23, sw 2B, j 02. Any other encoding is illegal.
- ext_sign=1 for addi, slti, lw, sw. ext_sign=0 for andi, ori.
- States and transitions:
  - FETCH: mem_req=1, addr_src=0, mem_we=0. Hold until mem_ready. On the ready cycle assert ir_w, pc_w, pc_src=0, then go to DECODE.
  - DECODE: ab_w=1.
    - nop goes to FETCH and retires.
    - j: pc_w=1, pc_src=1, goes to FETCH and retires.
    - R-type goes to EXEC_R. addi/andi/ori/slti go to EXEC_I. lw/sw go to MEM_ADDR.
    - Illegal goes to TRAP.
  - EXEC_R: alu_b_src=1, aluc per funct, aluout_w=1, then WB_ALU with rf_dst=0.
  - EXEC_I: alu_b_src=0, aluc per opcode, aluout_w=1, then WB_ALU with rf_dst=1.
  - WB_ALU: rf_w=1, wb_src=0. Retires, goes to FETCH.
  - MEM_ADDR: alu_b_src=0, aluc=0, aluout_w=1. lw goes to MEM_RD, sw goes to MEM_WR.
  - MEM_RD: mem_req=1, addr_src=1. Hold until mem_ready, then go to WB_MEM.
  - WB_MEM: rf_w=1, rf_dst=1, wb_src=1. Retires, goes to FETCH.
  - MEM_WR: mem_req=1, mem_we=1, addr_src=1. Hold until mem_ready. Retires, goes to FETCH.
  - TRAP: trap=1. All enables and mem_req are 0. Only reset exits.
- instret increments by 1 in the final cycle of each retired instruction. It wraps modulo 2^CNT_W and never saturates.

## Timing
- Reset (rst low, asynchronous): state=FETCH, trap=0, instret=0, all enables and mem_req=0 immediately. The first mem_req rises in the first cycle after rst deasserts.
- All outputs except instret and trap are a Moore/Mealy decode of the state, ir and mem_ready. instret and trap are registered.
- Handshake rules:
  - mem_req, mem_we and addr_src stay stable from assertion until the cycle in which mem_ready=1 is sampled.
  - mem_ready with mem_req=0 is ignored.
  - The state does not advance while waiting.
- Zero-wait latency (mem_ready high on the first request cycle): nop/j 2 cycles, R-type and I-type ALU 4, sw 4, lw 5. Each memory wait cycle adds 1.
- Reset mid-wait abandons the request; the same cycle mem_req=0.
- trap sets in the cycle after DECODE of an illegal encoding. instret is not incremented for it.

## Structure
- Package mc_pkg holds:
  - opcode and funct localparams
  - ALUC constants (ALU_ADD…ALU_SLT)
  - the state enum (FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, TRAP)
- Sub-module mc_decode: combinational ir → instruction class (rtype/itype/load/store/jump/nop/illegal), aluc and ext_sign. mc_ctrl holds the state register, output decode and counter.

## Test plan
- Reset, then add $3,$1,$2 (0x00221820) with mem_ready always 1: FETCH→DECODE→EXEC_R→WB_ALU, rf_w=1 with rf_dst=0, aluc=0 in EXEC_R; instret=1 after 4 cycles.
- lw $2,4($1) (0x8C220004) with mem_ready delayed 3 cycles in MEM_RD: mem_req/addr_src=1 held for 4 cycles, WB_MEM asserts rf_w, wb_src=1; total 8 cycles.
- sw then j 0x10 (0x08000004): mem_we=1 only in MEM_WR; j asserts pc_w, pc_src=1 in DECODE; instret=2 after 6 cycles.
- andi (0x30220F0F) vs slti (0x2822FFFF): ext_sign=0 / aluc=2, and ext_sign=1 / aluc=4, respectively.
- Illegal word 0xFC000000: trap=1 from the cycle after DECODE, mem_req stays 0 for 20 cycles, instret unchanged; rst low clears trap asynchronously.
- Reset asserted mid-FETCH wait: mem_req drops in the same cycle. Preload instret to all-ones via CNT_W=4 and 16 nops: instret wraps to 0.
